// File: rtl/telemetry_check_mc.sv
// telemetry_check_mc
//   Multi-channel telemetry packet checker. Each packet carries a sequence
//   number in its low SEQ_W bits and a payload above it that must equal the
//   sequence number replicated upward. Every channel runs its own
//   IDLE/ACQ/OK lock machine with an inactivity timeout. It also keeps
//   saturating total and mismatch counters, which are read back through a
//   registered select port.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     packet strobe (at most one packet per cycle)
//   in_chan      channel of the packet
//   in_data      packet: {payload, seq}
//   clear        synchronous counter clear, applied to channels in clear_mask
//   clear_mask   per-channel clear enable
//   rd_sel       counter readback channel select
//   rd_total     total packet count of rd_sel (registered)
//   rd_mismatch  mismatch count of rd_sel (registered)
//   link_ok      per-channel lock flag (registered)
//   all_ok       AND of link_ok
//   err_pulse    one-cycle pulse on a bad packet or an out-of-range channel
module telemetry_check_mc #(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int DATA_W     = 88,
    parameter int SEQ_W      = 16,
    parameter int CNT_W      = 32,
    parameter int GOOD_LIMIT = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_chan,
    input  logic [DATA_W-1:0] in_data,
    input  logic              clear,
    input  logic [NUM_CH-1:0] clear_mask,
    input  logic [CH_W-1:0]   rd_sel,
    output logic [CNT_W-1:0]  rd_total,
    output logic [CNT_W-1:0]  rd_mismatch,
    output logic [NUM_CH-1:0] link_ok,
    output logic              all_ok,
    output logic              err_pulse
);

    localparam int PAY_W = DATA_W - SEQ_W;
    localparam int REP   = PAY_W / SEQ_W + 1;
    localparam int GC_W  = $clog2(GOOD_LIMIT + 1);
    localparam int IC_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_OK
    } state_t;

    state_t           state     [NUM_CH];
    logic [SEQ_W-1:0] exp_seq   [NUM_CH];
    logic [GC_W-1:0]  good_cnt  [NUM_CH];
    logic [IC_W-1:0]  idle_cnt  [NUM_CH];
    logic [CNT_W-1:0] total_cnt [NUM_CH];
    logic [CNT_W-1:0] mism_cnt  [NUM_CH];

    logic [SEQ_W-1:0]     pkt_seq;
    logic [REP*SEQ_W-1:0] seq_rep;
    logic                 pay_ok;
    logic                 chan_ok;
    logic [NUM_CH-1:0]    hit;
    logic [NUM_CH-1:0]    good;
    logic [CNT_W-1:0]     rd_total_nxt;
    logic [CNT_W-1:0]     rd_mismatch_nxt;

    assign pkt_seq = in_data[SEQ_W-1:0];
    assign seq_rep = {REP{pkt_seq}};
    assign pay_ok  = (in_data[DATA_W-1:SEQ_W] == seq_rep[PAY_W-1:0]);
    assign chan_ok = (32'(in_chan) < NUM_CH);
    assign all_ok  = &link_ok;

    // In IDLE any sequence number is accepted; only the payload is judged.
    always_comb begin
        hit             = '0;
        good            = '0;
        rd_total_nxt    = '0;
        rd_mismatch_nxt = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            hit[c]  = in_valid && (32'(in_chan) == c);
            good[c] = pay_ok && ((state[c] == ST_IDLE) || (pkt_seq == exp_seq[c]));
            if (32'(rd_sel) == c) begin
                rd_total_nxt    = total_cnt[c];
                rd_mismatch_nxt = mism_cnt[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                state[c]     <= ST_IDLE;
                exp_seq[c]   <= '0;
                good_cnt[c]  <= '0;
                idle_cnt[c]  <= '0;
                total_cnt[c] <= '0;
                mism_cnt[c]  <= '0;
            end
            link_ok     <= '0;
            err_pulse   <= 1'b0;
            rd_total    <= '0;
            rd_mismatch <= '0;
        end else begin
            err_pulse   <= in_valid && (!chan_ok || |(hit & ~good));
            rd_total    <= rd_total_nxt;
            rd_mismatch <= rd_mismatch_nxt;

            for (int unsigned c = 0; c < NUM_CH; c++) begin
                // Counters: clear wins over the increment of the same cycle.
                if (clear && clear_mask[c]) begin
                    total_cnt[c] <= '0;
                    mism_cnt[c]  <= '0;
                end else if (hit[c]) begin
                    if (total_cnt[c] != '1)
                        total_cnt[c] <= total_cnt[c] + 1'b1;
                    if (!good[c] && (mism_cnt[c] != '1))
                        mism_cnt[c] <= mism_cnt[c] + 1'b1;
                end

                if (hit[c]) begin
                    // Every packet, good or bad, resynchronises the expected sequence.
                    exp_seq[c]  <= pkt_seq + 1'b1;
                    idle_cnt[c] <= '0;
                    case (state[c])
                        ST_IDLE: begin
                            if (good[c]) begin
                                good_cnt[c] <= GC_W'(1);
                                if (GOOD_LIMIT == 1) begin
                                    state[c]   <= ST_OK;
                                    link_ok[c] <= 1'b1;
                                end else begin
                                    state[c]   <= ST_ACQ;
                                end
                            end
                        end
                        ST_ACQ: begin
                            if (good[c]) begin
                                good_cnt[c] <= good_cnt[c] + 1'b1;
                                if (32'(good_cnt[c]) + 32'd1 >= GOOD_LIMIT) begin
                                    state[c]   <= ST_OK;
                                    link_ok[c] <= 1'b1;
                                end
                            end else begin
                                good_cnt[c] <= '0;
                            end
                        end
                        ST_OK: begin
                            if (!good[c]) begin
                                state[c]    <= ST_ACQ;
                                good_cnt[c] <= '0;
                                link_ok[c]  <= 1'b0;
                            end
                        end
                        default: begin
                            state[c]   <= ST_IDLE;
                            link_ok[c] <= 1'b0;
                        end
                    endcase
                end else if (idle_cnt[c] == IC_W'(TIMEOUT - 1)) begin
                    // Timed out: drop lock and hold the idle count (no wrap).
                    state[c]    <= ST_IDLE;
                    good_cnt[c] <= '0;
                    link_ok[c]  <= 1'b0;
                end else begin
                    idle_cnt[c] <= idle_cnt[c] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_telemetry_check_mc.sv
// Self-checking bench for telemetry_check_mc (4 channels, 3-bit channel index,
// 4-bit counters, short timeout). A spec-level model predicts the outputs for
// each driven cycle and queues them; a monitor pops and compares after each
// rising edge.
module tb_telemetry_check_mc;

    localparam int NUM_CH  = 4;
    localparam int CH_W    = 3;
    localparam int DATA_W  = 88;
    localparam int SEQ_W   = 16;
    localparam int CNT_W   = 4;
    localparam int GL      = 4;
    localparam int TO      = 64;
    localparam int MAXC    = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [CH_W-1:0]   in_chan;
    logic [DATA_W-1:0] in_data;
    logic              clear;
    logic [NUM_CH-1:0] clear_mask;
    logic [CH_W-1:0]   rd_sel;
    logic [CNT_W-1:0]  rd_total;
    logic [CNT_W-1:0]  rd_mismatch;
    logic [NUM_CH-1:0] link_ok;
    logic              all_ok;
    logic              err_pulse;

    telemetry_check_mc #(
        .NUM_CH(NUM_CH), .CH_W(CH_W), .DATA_W(DATA_W), .SEQ_W(SEQ_W),
        .CNT_W(CNT_W), .GOOD_LIMIT(GL), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_chan(in_chan),
        .in_data(in_data), .clear(clear), .clear_mask(clear_mask),
        .rd_sel(rd_sel), .rd_total(rd_total), .rd_mismatch(rd_mismatch),
        .link_ok(link_ok), .all_ok(all_ok), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0] lk;
        logic              err;
        logic [CNT_W-1:0]  rt;
        logic [CNT_W-1:0]  rm;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    // model state: 0 IDLE, 1 ACQ, 2 OK
    int          m_st   [NUM_CH];
    logic [15:0] m_exp  [NUM_CH];
    int          m_gc   [NUM_CH];
    int          m_idle [NUM_CH];
    int          m_tot  [NUM_CH];
    int          m_mm   [NUM_CH];
    logic [15:0] nseq   [NUM_CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-SEQ_W-1:0] exp_pay(input logic [15:0] s);
        logic [DATA_W-SEQ_W-1:0] p;
        for (int i = 0; i < DATA_W - SEQ_W; i++) p[i] = s[i % SEQ_W];
        return p;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_st[c] = 0; m_exp[c] = '0; m_gc[c] = 0; m_idle[c] = 0;
            m_tot[c] = 0; m_mm[c] = 0;
        end
    endtask

    // Drive one cycle of stimulus, predict the outputs after the next rising
    // edge, queue the prediction, then advance to the next falling edge.
    task automatic step(input bit v, input int ch, input logic [15:0] seq, input bit bad,
                        input bit clr, input logic [NUM_CH-1:0] mask, input int sel);
        exp_t e;
        logic [DATA_W-SEQ_W-1:0] p;
        bit good;
        p = exp_pay(seq);
        if (bad) p[0] = ~p[0];
        in_valid   = v;
        in_chan    = 3'(ch);
        in_data    = {p, seq};
        clear      = clr;
        clear_mask = mask;
        rd_sel     = 3'(sel);

        e.rt  = (sel < NUM_CH) ? 4'(m_tot[sel]) : 4'd0;
        e.rm  = (sel < NUM_CH) ? 4'(m_mm[sel])  : 4'd0;
        e.err = v && (ch >= NUM_CH);
        for (int c = 0; c < NUM_CH; c++) begin
            if (v && ch == c) begin
                good = !bad && (m_st[c] == 0 || seq == m_exp[c]);
                if (!good) e.err = 1'b1;
                if (clr && mask[c]) begin
                    m_tot[c] = 0; m_mm[c] = 0;
                end else begin
                    if (m_tot[c] < MAXC) m_tot[c]++;
                    if (!good && m_mm[c] < MAXC) m_mm[c]++;
                end
                m_exp[c]  = seq + 16'd1;
                m_idle[c] = 0;
                case (m_st[c])
                    0: if (good) begin m_gc[c] = 1; m_st[c] = (GL == 1) ? 2 : 1; end
                    1: if (good) begin m_gc[c]++; if (m_gc[c] == GL) m_st[c] = 2; end
                       else m_gc[c] = 0;
                    default: if (!good) begin m_st[c] = 1; m_gc[c] = 0; end
                endcase
                nseq[c] = seq + 16'd1;
            end else begin
                if (clr && mask[c]) begin m_tot[c] = 0; m_mm[c] = 0; end
                if (m_idle[c] == TO - 1) begin m_st[c] = 0; m_gc[c] = 0; end
                else m_idle[c]++;
            end
            e.lk[c] = (m_st[c] == 2);
        end
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic pkt(input int ch, input bit bad, input int sel);
        step(1'b1, ch, nseq[ch], bad, 1'b0, '0, sel);
    endtask

    task automatic idle(input int sel);
        step(1'b0, 0, 16'h0, 1'b0, 1'b0, '0, sel);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            chk("link_ok",     32'(link_ok),     32'(mon_e.lk));
            chk("all_ok",      32'(all_ok),      32'(&mon_e.lk));
            chk("err_pulse",   32'(err_pulse),   32'(mon_e.err));
            chk("rd_total",    32'(rd_total),    32'(mon_e.rt));
            chk("rd_mismatch", 32'(rd_mismatch), 32'(mon_e.rm));
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_chan = '0; in_data = '0;
        clear = 1'b0; clear_mask = '0; rd_sel = '0;
        model_reset();
        for (int c = 0; c < NUM_CH; c++) nseq[c] = '0;
        repeat (2) @(negedge clk);
        chk("rst_link_ok", 32'(link_ok), 0);
        chk("rst_all_ok", 32'(all_ok), 0);
        chk("rst_err", 32'(err_pulse), 0);
        chk("rst_rd_total", 32'(rd_total), 0);
        chk("rst_rd_mismatch", 32'(rd_mismatch), 0);
        rst_n = 1'b1;

        // ch0 seq 0..5, lock after the 4th, total 6
        for (int s = 0; s < 6; s++) step(1'b1, 0, 16'(s), 1'b0, 1'b0, '0, 0);
        idle(0);

        // ch1 lock, seq gap 10 -> 12, relock on 13..16
        for (int s = 6; s <= 10; s++) step(1'b1, 1, 16'(s), 1'b0, 1'b0, '0, 1);
        step(1'b1, 1, 16'd12, 1'b0, 1'b0, '0, 1);
        for (int s = 13; s <= 16; s++) step(1'b1, 1, 16'(s), 1'b0, 1'b0, '0, 1);
        idle(1);

        // ch2 sequence wrap
        for (int s = 16'hFFFA; s <= 16'hFFFF; s++) step(1'b1, 2, 16'(s), 1'b0, 1'b0, '0, 2);
        step(1'b1, 2, 16'h0000, 1'b0, 1'b0, '0, 2);
        idle(2);

        // clear ch0 coincident with a ch0 packet
        step(1'b1, 0, nseq[0], 1'b0, 1'b1, 4'b0001, 0);
        idle(0);
        idle(1);

        // lock all four, then keep 0..2 busy so ch3 times out alone
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < NUM_CH; c++) pkt(c, 1'b0, (r + c) % 8);
        for (int r = 0; r < 23; r++)
            for (int c = 0; c < 3; c++) pkt(c, 1'b0, (r * 3 + c) % 8);

        // mismatch saturation on ch1, then clear ch1 alone
        for (int i = 0; i < 16; i++) pkt(1, 1'b1, 1);
        step(1'b0, 0, 16'h0, 1'b0, 1'b1, 4'b0010, 1);
        idle(1);

        // out-of-range channels, then read every select value
        step(1'b1, 5, 16'h1234, 1'b0, 1'b0, '0, 0);
        step(1'b1, 7, 16'h0001, 1'b1, 1'b0, '0, 2);
        for (int s = 0; s < 8; s++) idle(s);

        // bad payload on ch3 while IDLE, then a fresh acquisition
        step(1'b1, 3, 16'h4000, 1'b1, 1'b0, '0, 3);
        step(1'b1, 3, 16'h4001, 1'b0, 1'b0, '0, 3);
        for (int i = 0; i < 3; i++) pkt(3, 1'b0, 3);
        idle(3);

        // relock ch0 then reset mid-packet
        for (int i = 0; i < 4; i++) pkt(0, 1'b0, 0);
        in_valid = 1'b1; in_chan = '0; in_data = {exp_pay(nseq[0]), nseq[0]};
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_link_ok", 32'(link_ok), 0);
        chk("mid_rst_all_ok", 32'(all_ok), 0);
        chk("mid_rst_rd_total", 32'(rd_total), 0);
        chk("mid_rst_rd_mismatch", 32'(rd_mismatch), 0);
        q.delete();
        model_reset();
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        for (int s = 0; s < 5; s++) step(1'b1, 0, 16'(16'h0100 + s), 1'b0, 1'b0, '0, 0);
        idle(0);
        idle(0);

        chk("queue_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/telemetry_check_mc.md
# telemetry_check_mc

Multi-channel successor to the single-stream telemetry checker. Sits downstream of the GT unpack stage in the telemetry clock domain. Checks each packet's sequence number and payload pattern per channel, and runs a per-channel link-lock state machine with an inactivity timeout. Keeps saturating total and mismatch counters per channel, read back through a registered select port, so multiple GT lanes share one checker instance.

## Interface
- NUM_CH, 4, number of independent channels (1..16)
- CH_W, 2, width of channel index, ≥ clog2(NUM_CH)
- DATA_W, 88, packet width
- SEQ_W, 16, sequence field width, in_data[SEQ_W-1:0]
- CNT_W, 32, counter width
- GOOD_LIMIT, 4, consecutive good packets needed to declare lock (≥1)
- TIMEOUT, 1024, idle cycles per channel before lock is dropped (≥2)

- clk  in  1  sole clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  packet strobe, one packet per cycle max
- in_chan  in  CH_W  channel of packet
- in_data  in  DATA_W  packet: seq in low SEQ_W bits, payload above
- clear  in  1  synchronous counter clear, qualified by clear_mask
- clear_mask  in  NUM_CH  channels affected by clear
- rd_sel  in  CH_W  counter readback select
- rd_total  out  CNT_W  total packets of selected channel
- rd_mismatch  out  CNT_W  mismatch packets of selected channel
- link_ok  out  NUM_CH  per-channel lock flag
- all_ok  out  1  AND of link_ok
- err_pulse  out  1  one-cycle pulse on any mismatch or bad channel

## Operation
- Expected payload is the seq field replicated upward and truncated to DATA_W-SEQ_W bits.
- A packet is good when the payload matches the expected payload and, in ACQ/OK, seq equals exp_seq[ch].
- Per-channel state: IDLE, ACQ, OK, each with exp_seq, good_cnt, idle_cnt.
- IDLE transitions:
  - On any packet: exp_seq ← seq+1 (mod 2^SEQ_W).
  - If the payload is good: go to ACQ with good_cnt = 1; if GOOD_LIMIT = 1, go directly to OK.
  - If the payload is bad: count a mismatch and stay in IDLE.
- ACQ transitions:
  - On a good packet: good_cnt+1; go to OK when good_cnt reaches GOOD_LIMIT.
  - On a bad packet: good_cnt ← 0, stay in ACQ, exp_seq ← seq+1 (resync).
- OK transitions:
  - On a bad packet: go to ACQ, good_cnt ← 0, exp_seq ← seq+1.
- Timeout, any state:
  - idle_cnt counts cycles with no packet on the channel and resets to 0 on a packet.
  - At TIMEOUT-1 without a packet, go to IDLE and hold idle_cnt there (no wrap).
- Sequence wrap: seq 0xFFFF followed by 0x0000 is good.
- Counters:
  - total increments on every packet for the channel; mismatch increments on every bad packet.
  - Both saturate at 2^CNT_W-1.
- Clear takes priority over increment in the same cycle: the counter goes to 0, and the packet is not counted. Sequence and state tracking still process that packet.
- Clear affects only channels with clear_mask set. It does not affect the FSM.
- in_chan ≥ NUM_CH: the packet is ignored by all channels and err_pulse is asserted.
- link_ok[ch] = (state==OK), registered.

## Timing
- Reset values: all states IDLE, all counters 0, exp_seq 0, idle_cnt 0, link_ok 0, all_ok 0, err_pulse 0, rd_* 0.
- A packet sampled at edge n updates counters, state, link_ok and err_pulse at edge n+1. all_ok is combinational from the link_ok registers.
- rd_total/rd_mismatch are registered. The value at edge n+1 is the counter of rd_sel as held during cycle n, before that cycle's update. rd_sel ≥ NUM_CH reads 0.
- Asserting rst_n low mid-packet clears everything immediately. The first packet after deassertion is processed normally.
- No backpressure: in_valid is accepted every cycle.

## Test plan
- Reset, then send ch0 seq 0..5 with good payloads → link_ok[0]=1 one cycle after the 4th packet; rd_sel=0 reads total=6, mismatch=0.
- ch1 locked; send seq 10, then 12 → mismatch=1, err_pulse for 1 cycle, link_ok[1]=0. Then send 13,14,15,16 → relock after the 4th.
- ch2 locked with seq 0xFFFE, 0xFFFF, 0x0000 → no mismatch; link_ok stays 1.
- ch3 locked, no packets for TIMEOUT cycles → link_ok[3] falls exactly TIMEOUT cycles after the last packet; all_ok falls with it.
- clear with clear_mask=4'b0001 on the same cycle as a ch0 packet → ch0 total=0; ch1 counters unchanged; ch0 link state unchanged.
- Force a counter to 2^CNT_W-2 (CNT_W=4 build), then send 3 packets → counter holds 15. Send a packet with in_chan=5 in a NUM_CH=4 build → err_pulse asserted, no counter changes.
